// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds bytes from N requesters to one UART transmitter.
// Define UART_ARB_LOCK_EN to keep the grant for a whole packet, up to the byte with req_last.
module uart_tx_arb #(
  parameter int unsigned N = 4
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [2:0]     grant_id,
  output logic           busy
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    SArb,
    SWaitBusy,
    SWaitDone,
    SHold
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   gnt_q;
  logic [N-1:0]      req_ready_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;

  logic              arb_found;
  logic [IdxW-1:0]   arb_idx;
  logic [IdxW-1:0]   pick_idx;
  logic [7:0]        pick_byte;
  logic              issue;
  logic [IdxW-1:0]   next_ptr;

`ifdef UART_ARB_LOCK_EN
  logic              pkt_last_q;
`else
  logic              unused_last;
  assign unused_last = ^req_last;
`endif

  // Two passes: indices at/after the pointer first, then wrap around to the low indices.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!arb_found && req_valid[i] && (i >= 32'(rr_ptr_q))) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!arb_found && req_valid[i]) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(i);
      end
    end
  end

  // In S_HOLD only the locked requester may send; otherwise the round-robin winner.
  always_comb begin
    pick_idx  = (state_q == SHold) ? gnt_q : arb_idx;
    pick_byte = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_idx == IdxW'(i)) begin
        pick_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    issue = 1'b0;
    if (tx_ready) begin
      if (state_q == SArb) begin
        issue = arb_found;
      end else if (state_q == SHold) begin
        issue = req_valid[gnt_q];
      end
    end
  end

  assign next_ptr = (32'(gnt_q) == N - 1) ? '0 : gnt_q + IdxW'(1);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= SArb;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      req_ready_q <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      pkt_last_q  <= 1'b0;
`endif
    end else begin
      tx_valid_q  <= 1'b0;
      req_ready_q <= '0;
      case (state_q)
        SArb, SHold: begin
          if (issue) begin
            gnt_q       <= pick_idx;
            tx_valid_q  <= 1'b1;
            req_ready_q <= N'(1) << pick_idx;
            tx_data_q   <= pick_byte;
            busy_q      <= 1'b1;
            state_q     <= SWaitBusy;
`ifdef UART_ARB_LOCK_EN
            pkt_last_q  <= req_last[pick_idx];
`endif
          end
        end
        // Transmitter still reports idle until it has seen the start pulse.
        SWaitBusy: begin
          if (!tx_ready) begin
            state_q <= SWaitDone;
          end
        end
        SWaitDone: begin
          if (tx_ready) begin
`ifdef UART_ARB_LOCK_EN
            if (pkt_last_q) begin
              rr_ptr_q <= next_ptr;
              busy_q   <= 1'b0;
              state_q  <= SArb;
            end else begin
              state_q  <= SHold;
            end
`else
            rr_ptr_q <= next_ptr;
            busy_q   <= 1'b0;
            state_q  <= SArb;
`endif
          end
        end
        default: state_q <= SArb;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign grant_id  = 3'(gnt_q);
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: directed scenarios plus randomized traffic against a
// transaction-level round-robin model with a simple transmitter model.
module tb_uart_tx_arb;

  localparam int unsigned N    = 4;
  localparam int unsigned MaxB = 12;

  logic           CLK = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [2:0]     grant_id;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_arb #(.N(N)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] d, input logic last);
    req_data[8*i +: 8] = d;
    req_last[i]        = last;
    req_valid[i]       = 1'b1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Transmitter accepts the pulse: goes busy, then idle again.
  task automatic xfer_done();
    tx_ready = 1'b0;
    tick();
    tx_ready = 1'b1;
    tick();
  endtask

  task automatic expect_pulse(input string tag, input int id, input logic [7:0] d);
    check_eq({tag, "_txv"}, 32'(tx_valid), 32'd1);
    check_eq({tag, "_id"},  32'(grant_id), id);
    check_eq({tag, "_dat"}, 32'(tx_data),  32'(d));
    check_eq({tag, "_rdy"}, 32'(req_ready), 32'd1 << id);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Random-phase model state
  logic [7:0]   mem_d [N][16];
  logic         mem_l [N][16];
  int           head [N];
  int           tot [N];
  int           drop [N];
  int           total, delivered, ptr_m, held, exp_g, tx_cnt;
  bit           seen_low, pend, lst;
  logic [N-1:0] p_valid;
  logic         p_txr;
  int           n0, n1;
  int           exp_id [5];
  logic [7:0]   exp_dat [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    tick();
    tick();
    check_eq("rst_txv",  32'(tx_valid),  32'd0);
    check_eq("rst_rdy",  32'(req_ready), 32'd0);
    check_eq("rst_dat",  32'(tx_data),   32'h00);
    check_eq("rst_id",   32'(grant_id),  32'd0);
    check_eq("rst_busy", 32'(busy),      32'd0);
    rst = 1'b0;

    // Single byte, then transmitter handshake hold-off
    set_byte(0, 8'h55, 1'b1);
    tick();
    expect_pulse("one", 0, 8'h55);
    check_eq("one_busy", 32'(busy), 32'd1);
    set_byte(0, 8'h66, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("hs_txv",  32'(tx_valid),  32'd0);
      check_eq("hs_rdy",  32'(req_ready), 32'd0);
      check_eq("hs_busy", 32'(busy),      32'd1);
    end
    tx_ready = 1'b0;
    tick();
    tx_ready = 1'b1;
    tick();
    check_eq("one_idle", 32'(busy),     32'd0);
    check_eq("one_txv0", 32'(tx_valid), 32'd0);
    tick();
    expect_pulse("hs_next", 0, 8'h66);
    req_valid = '0;
    xfer_done();

    // Contention from reset
    do_reset();
    for (int i = 0; i < 4; i++) set_byte(i, 8'hA0 + 8'(i), 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_pulse("ctn", i, 8'hA0 + 8'(i));
      req_valid[i] = 1'b0;
      xfer_done();
    end

    // Pointer follows last grant
    set_byte(2, 8'h22, 1'b1);
    tick();
    expect_pulse("ptr_a", 2, 8'h22);
    req_valid = '0;
    xfer_done();
    set_byte(0, 8'h30, 1'b1);
    set_byte(3, 8'h33, 1'b1);
    tick();
    expect_pulse("ptr_b", 3, 8'h33);
    req_valid[3] = 1'b0;
    xfer_done();
    tick();
    expect_pulse("ptr_c", 0, 8'h30);
    req_valid = '0;
    xfer_done();

    // Packet of three bytes from requester 1 against a steady requester 0
    do_reset();
    set_byte(0, 8'h11, 1'b1);
    tick();
    expect_pulse("pre", 0, 8'h11);
    req_valid = '0;
    xfer_done();
    n0 = 0;
    n1 = 0;
    set_byte(1, 8'hB0, 1'b0);
    set_byte(0, 8'hC0, 1'b1);
`ifdef UART_ARB_LOCK_EN
    exp_id  = '{1, 1, 1, 0, 0};
    exp_dat = '{8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1};
`else
    exp_id  = '{1, 0, 1, 0, 1};
    exp_dat = '{8'hB0, 8'hC0, 8'hB1, 8'hC1, 8'hB2};
`endif
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_pulse("pkt", exp_id[k], exp_dat[k]);
      if (req_ready[1]) begin
        n1++;
        if (n1 < 3) set_byte(1, 8'hB0 + 8'(n1), n1 == 2);
        else req_valid[1] = 1'b0;
      end
      if (req_ready[0]) begin
        n0++;
        set_byte(0, 8'hC0 + 8'(n0), 1'b1);
      end
      xfer_done();
    end
    req_valid = '0;

    // Reset while waiting for the transmitter, with competing activity in the same cycle
    do_reset();
    set_byte(2, 8'h22, 1'b1);
    tick();
    expect_pulse("mr_a", 2, 8'h22);
    req_valid = '0;
    xfer_done();
    set_byte(3, 8'h33, 1'b1);
    tick();
    expect_pulse("mr_b", 3, 8'h33);
    req_valid = '0;
    tx_ready  = 1'b0;
    tick();
    rst      = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_byte(i, 8'h40 + 8'(i), 1'b1);
    tick();
    check_eq("mr_txv",  32'(tx_valid),  32'd0);
    check_eq("mr_rdy",  32'(req_ready), 32'd0);
    check_eq("mr_busy", 32'(busy),      32'd0);
    check_eq("mr_id",   32'(grant_id),  32'd0);
    rst = 1'b0;
    tick();
    expect_pulse("mr_first", 0, 8'h40);
    req_valid = '0;
    xfer_done();

    // Randomized traffic
    do_reset();
    total     = 0;
    delivered = 0;
    for (int i = 0; i < N; i++) begin
      tot[i]  = int'($urandom_range(3, MaxB));
      head[i] = 0;
      drop[i] = 0;
      total  += tot[i];
      for (int j = 0; j < tot[i]; j++) begin
        mem_d[i][j] = 8'($urandom);
        mem_l[i][j] = (j == tot[i] - 1) || ($urandom_range(0, 2) == 0);
      end
    end
    ptr_m    = 0;
    held     = -1;
    seen_low = 1'b1;
    pend     = 1'b0;
    tx_cnt   = 0;
    for (int cyc = 0; cyc < 20000 && delivered < total; cyc++) begin
      p_valid = req_valid;
      p_txr   = tx_ready;
      tick();
      exp_g = -1;
      if (tx_valid) begin
        exp_g = (held >= 0) ? held : rr_pick(p_valid, ptr_m);
        check_eq("rnd_pulse_ok", (p_txr && exp_g >= 0 && p_valid[exp_g]) ? 32'd1 : 32'd0, 32'd1);
        check_eq("rnd_spacing", 32'(seen_low), 32'd1);
        check_eq("rnd_busy", 32'(busy), 32'd1);
        seen_low = 1'b0;
        if (exp_g >= 0 && head[exp_g] < 16) begin
          check_eq("rnd_id",  32'(grant_id),  exp_g);
          check_eq("rnd_rdy", 32'(req_ready), 32'd1 << exp_g);
          check_eq("rnd_dat", 32'(tx_data),   32'(mem_d[exp_g][head[exp_g]]));
          lst = mem_l[exp_g][head[exp_g]];
          head[exp_g]++;
          delivered++;
          drop[exp_g] = 2;
`ifdef UART_ARB_LOCK_EN
          if (lst) begin
            held  = -1;
            ptr_m = (exp_g + 1) % N;
          end else begin
            held = exp_g;
          end
`else
          ptr_m = (exp_g + 1) % N;
`endif
        end
      end else begin
        check_eq("rnd_rdy_idle", 32'(req_ready), 32'd0);
      end
      if (!p_txr) seen_low = 1'b1;

      // Transmitter: idle flag drops the cycle after a pulse, returns after a few cycles.
      if (pend) begin
        tx_ready = 1'b0;
        tx_cnt   = int'($urandom_range(1, 6));
        pend     = 1'b0;
      end else if (tx_valid) begin
        pend = 1'b1;
      end else if (tx_cnt > 1) begin
        tx_cnt--;
      end else begin
        tx_cnt   = 0;
        tx_ready = ($urandom_range(0, 4) != 0);
      end

      // Requesters hold through the accept cycle, then present their next byte.
      for (int i = 0; i < N; i++) begin
        if (drop[i] == 2) begin
          drop[i] = 1;
        end else begin
          if (drop[i] == 1) begin
            req_valid[i] = 1'b0;
            drop[i]      = 0;
          end
          if (!req_valid[i] && head[i] < tot[i] && $urandom_range(0, 2) != 0) begin
            set_byte(i, mem_d[i][head[i]], mem_l[i][head[i]]);
          end
        end
      end
    end
    check_eq("rnd_all_delivered", delivered, total);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
